// File: rtl/sram_arbiter.sv
// Round-robin arbiter and sequencer sharing one 64x64 SRAM between two requesters.
// Define SRAM_ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST beats.
module sram_arbiter #(
   parameter int DW        = 64,
   parameter int AW        = 6,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_0,
   input  logic          req_1,
   input  logic          we_0,
   input  logic          we_1,
   input  logic [AW-1:0] addr_0,
   input  logic [AW-1:0] addr_1,
   input  logic [DW-1:0] wdata_0,
   input  logic [DW-1:0] wdata_1,
   output logic          gnt_0,
   output logic          gnt_1,
   output logic          rsp_valid_0,
   output logic          rsp_valid_1,
   output logic [DW-1:0] rsp_data,
   output logic          sram_csb,
   output logic          sram_wsb,
   output logic [AW-1:0] sram_waddr,
   output logic [AW-1:0] sram_raddr,
   output logic [DW-1:0] sram_wdata,
   input  logic [DW-1:0] sram_rdata
);

   logic ptr, ptr_nxt;   // requester favoured on contention
   logic win, acc;

   always_comb begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
      if (req_0 && req_1) begin
         gnt_0 = ~ptr;
         gnt_1 = ptr;
      end else begin
         gnt_0 = req_0;
         gnt_1 = req_1;
      end
      acc = gnt_0 | gnt_1;
      win = gnt_1;
   end

   always_comb begin
      sram_csb   = 1'b1;
      sram_wsb   = 1'b1;
      sram_waddr = '0;
      sram_raddr = '0;
      sram_wdata = '0;
      if (gnt_0) begin
         sram_csb   = 1'b0;
         sram_wsb   = ~we_0;
         sram_waddr = addr_0;
         sram_raddr = addr_0;
         sram_wdata = wdata_0;
      end else if (gnt_1) begin
         sram_csb   = 1'b0;
         sram_wsb   = ~we_1;
         sram_waddr = addr_1;
         sram_raddr = addr_1;
         sram_wdata = wdata_1;
      end
   end

`ifdef SRAM_ARB_BURST_EN
   localparam logic [3:0] MB = 4'(MAX_BURST);
   logic [3:0] cnt, cnt_nxt, cnt_inc;

   // A beat from a non-owner starts a fresh burst for it.
   always_comb begin
      cnt_inc = ((win == ptr) ? cnt : 4'd0) + 4'd1;
      ptr_nxt = ptr;
      cnt_nxt = 4'd0;
      if (acc) begin
         if (cnt_inc >= MB) begin
            ptr_nxt = ~win;
            cnt_nxt = 4'd0;
         end else begin
            ptr_nxt = win;
            cnt_nxt = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= 4'd0;
      else        cnt <= cnt_nxt;
   end
`else
   always_comb ptr_nxt = acc ? ~win : ptr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= 1'b0;
         rsp_valid_0 <= 1'b0;
         rsp_valid_1 <= 1'b0;
      end else begin
         ptr         <= ptr_nxt;
         rsp_valid_0 <= gnt_0 & ~we_0;
         rsp_valid_1 <= gnt_1 & ~we_1;
      end
   end

   // SRAM output is already registered, so data lines up with the valid strobe.
   assign rsp_data = sram_rdata;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one 64-entry x 64-bit single-clock SRAM macro with active-low chip/write enables and separate read/write address inputs.
- Shares that SRAM between two matrix-engine clients, for example the weight loader and the compute array.
- Issues at most one access per cycle, uses round-robin fairness, and returns read data with a per-requester valid strobe one cycle after the grant.

Parameters:
- DW, 64, data width in bits; must match the SRAM word.
- AW, 6, address width; SRAM depth is 2**AW.
- MAX_BURST, 4, maximum consecutive grants to one owner; used only when SRAM_ARB_BURST_EN is defined; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_0, req_1  input  1 each  access request from requester 0 / 1.
- we_0, we_1  input  1 each  1 = write, 0 = read; qualified by req.
- addr_0, addr_1  input  AW each  word address.
- wdata_0, wdata_1  input  DW each  write data.
- gnt_0, gnt_1  output  1 each  grant; combinational; an access is accepted on any rising edge where req_x && gnt_x.
- rsp_valid_0, rsp_valid_1  output  1 each  registered; read data for requester x is valid this cycle.
- rsp_data  output  DW  read data shared by both requesters; qualified by rsp_valid_x.
- sram_csb  output  1  SRAM chip enable, active low.
- sram_wsb  output  1  SRAM write enable, active low.
- sram_waddr  output  AW  SRAM write address.
- sram_raddr  output  AW  SRAM read address.
- sram_wdata  output  DW  SRAM write data.
- sram_rdata  input  DW  SRAM read data, registered inside the SRAM.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n = 0: rsp_valid_0 = rsp_valid_1 = 0, priority pointer = 0 (requester 0 favoured), burst counter = 0.
  - Reset asserted mid-operation clears any pending response; no rsp_valid is produced for an access accepted in the cycle reset asserts.
- Grant logic is combinational and the grant is one-hot.
  - Only one requester requesting: it is granted.
  - Both requesting: the requester named by the priority pointer is granted.
  - Neither requesting: gnt_0 = gnt_1 = 0.
- SRAM drive is combinational from the winner.
  - sram_csb = 0 iff any grant.
  - sram_wsb = 0 iff the winner's we = 1.
  - sram_waddr = sram_raddr = winner addr; sram_wdata = winner wdata.
  - Idle drive: sram_csb = 1, sram_wsb = 1, addresses = 0, sram_wdata = 0.
- Pointer update: after every accepted access, the pointer moves to the non-winning requester. With no access it holds.
- Read latency:
  - A read accepted at edge N sets rsp_valid_x = 1 for exactly the cycle after edge N.
  - rsp_data = sram_rdata, passed straight through with no added register.
  - Back-to-back reads give back-to-back valids in order.
- Writes produce no response. The SRAM's incidental read during a write cycle is ignored; rsp_valid stays 0.
- Read and write from different requesters never occur in the same cycle. A read after a write to the same address returns the new data, because the write lands at edge N and the read samples no earlier than edge N+1.
- A requester may change addr/we/wdata only after acceptance or while req = 0. Dropping req before grant is legal and has no side effects.
- Address wrap does not apply: AW fully covers the depth.

Optional Feature:
- Macro: SRAM_ARB_BURST_EN.
- When defined:
  - The current owner keeps the grant while its req stays high, for up to MAX_BURST consecutive accepted beats, even if the other requester is waiting.
  - A 4-bit burst counter increments per accepted beat. Ownership passes and the counter clears when the owner drops req or the counter reaches MAX_BURST.
  - An idle cycle also clears the counter.
- When undefined: the burst counter and its logic are absent, and strict alternation on every accepted beat applies when both requesters are active.

Test Plan:
- Reset, then req_0 write addr 5 data 0x1122334455667788; next cycle req_0 read addr 5 -> gnt_0 = 1 both cycles, sram_wsb = 0 then 1, and the cycle after the read rsp_valid_0 = 1 with rsp_data = 0x1122334455667788.
- Both requesters read continuously (addr_0 = 1, addr_1 = 2, preloaded 0xA / 0xB), burst feature off -> grants alternate 0,1,0,1; rsp_valid alternates one cycle later with data 0xA, 0xB.
- Burst feature on, MAX_BURST = 4, both requesting -> 4 consecutive gnt_0, then 4 gnt_1, repeating.
- Only req_1 active for 3 cycles -> gnt_1 every cycle, gnt_0 = 0, no stalls; a following single req_0 is granted immediately.
- Assert rst_n = 0 in the cycle after a read is accepted -> rsp_valid_x forced to 0 asynchronously; after release the first contested grant goes to requester 0.
- No requests for 10 cycles -> sram_csb = 1, sram_wsb = 1, no rsp_valid, SRAM contents unchanged.
